// File: rtl/lcd_text_writer.sv
// lcd_text_writer: writes an NUM_LINES x LINE_LENGTH text frame to an HD44780 LCD as 4-bit nibbles
// Ports: CLK/RESET (sync, active high); sendText/forceFull start an update of the latched `text` frame;
// busy/sendingDone report progress; commandToSend/commandToSendRs/read_busy/sendCommand_tick drive the
// nibble sender, which answers each tick with a commandDone pulse.
module lcd_text_writer #(
  parameter int LINE_LENGTH    = 16,
  parameter int NUM_LINES      = 2,
  parameter int SKIP_UNCHANGED = 0
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              sendText,
  input  logic                              forceFull,
  input  logic [8*LINE_LENGTH*NUM_LINES-1:0] text,
  output logic                              busy,
  output logic                              sendingDone,
  input  logic                              commandDone,
  output logic [3:0]                        commandToSend,
  output logic                              commandToSendRs,
  output logic                              read_busy,
  output logic                              sendCommand_tick
);
  localparam int CW = $clog2(LINE_LENGTH + 1);
  localparam int FW = 8 * LINE_LENGTH * NUM_LINES;
  typedef enum logic [3:0] {IDLE, SCAN, SET_ADDR, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, NEXT, DONE} state_t;
  state_t state_q, state_d;
  logic [FW-1:0] frame_q, frame_d, shadow_q, shadow_d;
  logic shadow_valid_q, shadow_valid_d, full_q, full_d, cur_valid_q, cur_valid_d, brs_q, brs_d;
  logic [1:0] line_q, line_d, cur_line_q, cur_line_d, nxt_line;
  logic [CW-1:0] col_q, col_d, cur_col_q, cur_col_d, nxt_col;
  logic [7:0] byte_q, byte_d, ch, sh;
  logic [6:0] base, addr;
  logic last, at_cursor, wrap, busy_d, done_d, tick_d, rs_d, rb_d;
  logic [3:0] cmd_d;
  int pos;
  assign pos = 8 * (int'(line_q) * LINE_LENGTH + int'(col_q));
  assign ch = frame_q[pos +: 8];
  assign sh = shadow_q[pos +: 8];
  assign base = line_q == 2'd0 ? 7'h00 : line_q == 2'd1 ? 7'h40 : line_q == 2'd2 ? 7'h14 : 7'h54;
  assign addr = base + 7'(col_q);
  assign wrap = col_q == CW'(LINE_LENGTH - 1);
  assign last = wrap && line_q == 2'(NUM_LINES - 1);
  assign nxt_col = wrap ? '0 : col_q + 1'b1;
  assign nxt_line = wrap ? line_q + 1'b1 : line_q;
  // the tracked cursor makes a set-address redundant for consecutive changed characters
  assign at_cursor = cur_valid_q && cur_line_q == line_q && cur_col_q == col_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q          <= IDLE;
      frame_q          <= '0;
      shadow_q         <= '0;
      shadow_valid_q   <= 1'b0;
      full_q           <= 1'b0;
      cur_valid_q      <= 1'b0;
      brs_q            <= 1'b0;
      line_q           <= '0;
      col_q            <= '0;
      cur_line_q       <= '0;
      cur_col_q        <= '0;
      byte_q           <= '0;
      busy             <= 1'b0;
      sendingDone      <= 1'b0;
      sendCommand_tick <= 1'b0;
      commandToSend    <= '0;
      commandToSendRs  <= 1'b0;
      read_busy        <= 1'b0;
    end else begin
      state_q          <= state_d;
      frame_q          <= frame_d;
      shadow_q         <= shadow_d;
      shadow_valid_q   <= shadow_valid_d;
      full_q           <= full_d;
      cur_valid_q      <= cur_valid_d;
      brs_q            <= brs_d;
      line_q           <= line_d;
      col_q            <= col_d;
      cur_line_q       <= cur_line_d;
      cur_col_q        <= cur_col_d;
      byte_q           <= byte_d;
      busy             <= busy_d;
      sendingDone      <= done_d;
      sendCommand_tick <= tick_d;
      commandToSend    <= cmd_d;
      commandToSendRs  <= rs_d;
      read_busy        <= rb_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    frame_d        = frame_q;
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    full_d         = full_q;
    cur_valid_d    = cur_valid_q;
    brs_d          = brs_q;
    line_d         = line_q;
    col_d          = col_q;
    cur_line_d     = cur_line_q;
    cur_col_d      = cur_col_q;
    byte_d         = byte_q;
    case (state_q)
      IDLE: if (sendText) begin
        state_d     = SCAN;
        frame_d     = text;
        full_d      = SKIP_UNCHANGED == 0 || forceFull || !shadow_valid_q;
        line_d      = '0;
        col_d       = '0;
        cur_valid_d = 1'b0;
      end
      SCAN: if (full_q ? col_q == '0 : ch != sh && !at_cursor) state_d = SET_ADDR;
      else if (full_q || ch != sh) begin
        state_d = SEND_HI;
        byte_d  = ch;
        brs_d   = 1'b1;
      end else begin
        state_d = last ? DONE : SCAN;
        line_d  = nxt_line;
        col_d   = nxt_col;
      end
      SET_ADDR: begin
        state_d     = SEND_HI;
        byte_d      = {1'b1, addr};
        brs_d       = 1'b0;
        cur_valid_d = 1'b1;
        cur_line_d  = line_q;
        cur_col_d   = col_q;
      end
      SEND_HI: state_d = WAIT_HI;
      // a commandDone coincident with our own tick belongs to an older nibble
      WAIT_HI: if (commandDone && !sendCommand_tick) state_d = SEND_LO;
      SEND_LO: state_d = WAIT_LO;
      WAIT_LO: if (commandDone && !sendCommand_tick) state_d = NEXT;
      NEXT: if (!brs_q) begin
        state_d = SEND_HI;
        byte_d  = ch;
        brs_d   = 1'b1;
      end else begin
        if (SKIP_UNCHANGED != 0) shadow_d[pos +: 8] = ch;
        cur_col_d = col_q + 1'b1;
        state_d   = last ? DONE : SCAN;
        line_d    = nxt_line;
        col_d     = nxt_col;
      end
      DONE: begin
        state_d = IDLE;
        if (SKIP_UNCHANGED != 0 && full_q) shadow_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tick_d = state_q == SEND_HI || state_q == SEND_LO;
    cmd_d  = state_q == SEND_HI ? byte_q[7:4] : state_q == SEND_LO ? byte_q[3:0] : commandToSend;
    rs_d   = tick_d ? brs_q : commandToSendRs;
    rb_d   = state_q == SEND_HI ? 1'b0 : state_q == SEND_LO ? 1'b1 : read_busy;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
endmodule

// File: tb/tb_lcd_text_writer.sv
// tb_lcd_text_writer: directed checks of lcd_text_writer in full, shadow-compare and 4x20 configurations
module tb_lcd_text_writer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int n_chk = 0, n_fail = 0;

  logic send_a = 0, ff_a = 0, busy_a, done_a, cd_a, rs_a, rb_a, tick_a;
  logic send_b = 0, ff_b = 0, busy_b, done_b, cd_b, rs_b, rb_b, tick_b;
  logic send_c = 0, ff_c = 0, busy_c, done_c, cd_c, rs_c, rb_c, tick_c;
  logic [3:0] cmd_a, cmd_b, cmd_c, hi_a, hi_b, hi_c;
  logic [255:0] text_a = '0, text_b = '0;
  logic [639:0] text_c = '0;
  logic [2:0] sr_a = '0, sr_b = '0, sr_c = '0;
  int ticks_a = 0, ticks_b = 0, ticks_c = 0, dones_a = 0, dones_b = 0, dones_c = 0;
  logic [8:0] bytes_a[$], bytes_b[$], bytes_c[$];
  logic [5:0] nib_a[$];

  lcd_text_writer dut_a (.CLK(clk), .RESET(rst), .sendText(send_a), .forceFull(ff_a), .text(text_a),
    .busy(busy_a), .sendingDone(done_a), .commandDone(cd_a), .commandToSend(cmd_a),
    .commandToSendRs(rs_a), .read_busy(rb_a), .sendCommand_tick(tick_a));
  lcd_text_writer #(.SKIP_UNCHANGED(1)) dut_b (.CLK(clk), .RESET(rst), .sendText(send_b), .forceFull(ff_b),
    .text(text_b), .busy(busy_b), .sendingDone(done_b), .commandDone(cd_b), .commandToSend(cmd_b),
    .commandToSendRs(rs_b), .read_busy(rb_b), .sendCommand_tick(tick_b));
  lcd_text_writer #(.LINE_LENGTH(20), .NUM_LINES(4)) dut_c (.CLK(clk), .RESET(rst), .sendText(send_c),
    .forceFull(ff_c), .text(text_c), .busy(busy_c), .sendingDone(done_c), .commandDone(cd_c),
    .commandToSend(cmd_c), .commandToSendRs(rs_c), .read_busy(rb_c), .sendCommand_tick(tick_c));

  // nibble sender model: commandDone three cycles after each tick
  always @(posedge clk) begin
    sr_a <= {sr_a[1:0], tick_a};
    sr_b <= {sr_b[1:0], tick_b};
    sr_c <= {sr_c[1:0], tick_c};
  end
  assign cd_a = sr_a[2];
  assign cd_b = sr_b[2];
  assign cd_c = sr_c[2];

  always @(negedge clk) begin
    if (tick_a) begin
      ticks_a++;
      nib_a.push_back({rs_a, rb_a, cmd_a});
      if (rb_a) bytes_a.push_back({rs_a, hi_a, cmd_a}); else hi_a = cmd_a;
    end
    if (tick_b) begin
      ticks_b++;
      if (rb_b) bytes_b.push_back({rs_b, hi_b, cmd_b}); else hi_b = cmd_b;
    end
    if (tick_c) begin
      ticks_c++;
      if (rb_c) bytes_c.push_back({rs_c, hi_c, cmd_c}); else hi_c = cmd_c;
    end
    if (done_a) dones_a++;
    if (done_b) dones_b++;
    if (done_c) dones_c++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int sel, input logic f);
    @(negedge clk);
    if (sel == 0) begin send_a = 1; ff_a = f; end
    else if (sel == 1) begin send_b = 1; ff_b = f; end
    else begin send_c = 1; ff_c = f; end
    @(negedge clk);
    send_a = 0; send_b = 0; send_c = 0; ff_a = 0; ff_b = 0; ff_c = 0;
  endtask

  task automatic wait_done(input int sel, input string tag);
    int i;
    i = 0;
    while (!(sel == 0 ? done_a : sel == 1 ? done_b : done_c) && i < 4000) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    chk({tag, " finished"}, 32'(i < 4000), 1);
  endtask

  function automatic logic [255:0] mk2(input string l0, input string l1);
    logic [255:0] f;
    for (int c = 0; c < 16; c++) begin
      f[8*c +: 8] = l0[c];
      f[8*(16+c) +: 8] = l1[c];
    end
    return f;
  endfunction

  initial begin
    int t0, b0, d0, cyc, n, i;
    rst = 1;
    repeat (3) @(negedge clk);
    chk("reset a", 32'({busy_a, done_a, tick_a, cmd_a, rs_a, rb_a}), 0);
    chk("reset b", 32'({busy_b, done_b, tick_b, cmd_b, rs_b, rb_b}), 0);
    chk("reset c", 32'({busy_c, done_c, tick_c, cmd_c, rs_c, rb_c}), 0);
    rst = 0;
    @(negedge clk);

    text_a = mk2("HELLO WORLD     ", "0123456789ABCDEF");
    pulse(0, 0);
    chk("a busy after accept", 32'(busy_a), 1);
    wait_done(0, "a full");
    chk("a ticks", 32'(ticks_a), 68);
    chk("a dones", 32'(dones_a), 1);
    chk("a nib0", 32'(nib_a[0]), 32'h08);
    chk("a nib1", 32'(nib_a[1]), 32'h10);
    chk("a nib2", 32'(nib_a[2]), 32'h24);
    chk("a nib3", 32'(nib_a[3]), 32'h38);
    chk("a byte count", 32'(bytes_a.size()), 34);
    chk("a line1 addr", 32'(bytes_a[17]), 32'h0C0);
    chk("a line1 char0", 32'(bytes_a[18]), 32'h130);
    chk("a last char", 32'(bytes_a[33]), 32'h146);
    chk("a idle busy", 32'(busy_a), 0);

    text_b = mk2("HELLO WORLD     ", "0123456789ABCDEF");
    text_b[8*15 +: 8] = 8'h00;
    pulse(1, 0);
    wait_done(1, "b first");
    chk("b first ticks", 32'(ticks_b), 68);
    chk("b zero char", 32'(bytes_b[16]), 32'h100);

    t0 = ticks_b; d0 = dones_b;
    pulse(1, 0);
    chk("b nochg busy start", 32'(busy_b), 1);
    cyc = 1;
    while (!done_b && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("b nochg done cycle", 32'(cyc), 33);
    chk("b nochg busy at done", 32'(busy_b), 1);
    @(negedge clk);
    chk("b nochg busy end", 32'(busy_b), 0);
    chk("b nochg ticks", 32'(ticks_b - t0), 0);
    chk("b nochg dones", 32'(dones_b - d0), 1);

    t0 = ticks_b; b0 = bytes_b.size();
    text_b[8*(16+3) +: 8] = "x";
    text_b[8*(16+4) +: 8] = "y";
    pulse(1, 0);
    wait_done(1, "b two adjacent");
    chk("b adj ticks", 32'(ticks_b - t0), 6);
    chk("b adj addr", 32'(bytes_b[b0]), 32'h0C3);
    chk("b adj c3", 32'(bytes_b[b0+1]), 32'h178);
    chk("b adj c4", 32'(bytes_b[b0+2]), 32'h179);

    t0 = ticks_b; b0 = bytes_b.size();
    text_b[8*(16+3) +: 8] = "p";
    text_b[8*(16+10) +: 8] = "q";
    pulse(1, 0);
    wait_done(1, "b two apart");
    chk("b apart ticks", 32'(ticks_b - t0), 8);
    chk("b apart addr3", 32'(bytes_b[b0]), 32'h0C3);
    chk("b apart c3", 32'(bytes_b[b0+1]), 32'h170);
    chk("b apart addr10", 32'(bytes_b[b0+2]), 32'h0CA);
    chk("b apart c10", 32'(bytes_b[b0+3]), 32'h171);

    d0 = dones_b;
    pulse(1, 1);
    n = 0; i = 0;
    while (n < 7 && i < 2000) begin
      @(negedge clk);
      i++;
      if (tick_b && rb_b) n++;
    end
    chk("b reached char5 low", 32'(n), 7);
    rst = 1;
    @(negedge clk);
    chk("b reset outputs", 32'({busy_b, done_b, tick_b, cmd_b, rs_b, rb_b}), 0);
    rst = 0;
    repeat (20) @(negedge clk);
    chk("b reset no done", 32'(dones_b - d0), 0);

    t0 = ticks_b; b0 = bytes_b.size();
    pulse(1, 0);
    wait_done(1, "b after reset");
    chk("b after reset ticks", 32'(ticks_b - t0), 68);
    chk("b after reset zero char", 32'(bytes_b[b0+16]), 32'h100);

    t0 = ticks_b;
    pulse(1, 1);
    wait_done(1, "b force");
    chk("b force ticks", 32'(ticks_b - t0), 68);

    t0 = ticks_a; b0 = bytes_a.size(); d0 = dones_a;
    text_a = mk2("abcdefghijklmnop", "qrstuvwxyz012345");
    pulse(0, 0);
    repeat (30) @(negedge clk);
    text_a = mk2("ZZZZZZZZZZZZZZZZ", "ZZZZZZZZZZZZZZZZ");
    pulse(0, 0);
    wait_done(0, "a latched");
    chk("a latched ticks", 32'(ticks_a - t0), 68);
    chk("a latched dones", 32'(dones_a - d0), 1);
    chk("a latched c0", 32'(bytes_a[b0+1]), 32'h161);
    chk("a latched c15", 32'(bytes_a[b0+16]), 32'h170);
    chk("a latched addr1", 32'(bytes_a[b0+17]), 32'h0C0);
    chk("a latched last", 32'(bytes_a[b0+33]), 32'h135);
    repeat (10) @(negedge clk);
    chk("a no second update", 32'(ticks_a - t0), 68);

    for (int l = 0; l < 4; l++)
      for (int c = 0; c < 20; c++) text_c[8*(20*l+c) +: 8] = 8'(65 + l);
    pulse(2, 0);
    wait_done(2, "c full");
    chk("c ticks", 32'(ticks_c), 168);
    chk("c addr0", 32'(bytes_c[0]), 32'h080);
    chk("c char0", 32'(bytes_c[1]), 32'h141);
    chk("c addr1", 32'(bytes_c[21]), 32'h0C0);
    chk("c char1", 32'(bytes_c[22]), 32'h142);
    chk("c addr2", 32'(bytes_c[42]), 32'h094);
    chk("c addr3", 32'(bytes_c[63]), 32'h0D4);
    chk("c dones", 32'(dones_c), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_text_writer.md
# lcd_text_writer

Parametrised successor to the two-line HD44780 text sender. It writes an N-line × M-column text frame to a character LCD in 4-bit mode. It sits between the application (which supplies the text frame) and the existing nibble-level command sender (which drives the LCD bus and reports completion). A snapshot of the frame is latched when an update starts. An optional shadow-compare mode sends only the characters that changed since the last update, cutting bus traffic for mostly static displays.

## Interface
Parameters:
- LINE_LENGTH, 16: characters per line, 1..20.
- NUM_LINES, 2: lines, 1..4. DDRAM base addresses for lines 0..3 are fixed at 0x00, 0x40, 0x14, 0x54.
- SKIP_UNCHANGED, 0: 1 enables shadow-compare mode.

Ports:
- CLK  in  1  single clock.
- RESET  in  1  synchronous, active-high reset.
- sendText  in  1  start request; honoured only in IDLE.
- forceFull  in  1  sampled with sendText; 1 forces a full rewrite in either mode.
- text  in  8·LINE_LENGTH·NUM_LINES  frame; char c of line l = text[8·(l·LINE_LENGTH+c) +: 8].
- busy  out  1  high from the cycle after an accepted sendText until sendingDone.
- sendingDone  out  1  one-cycle pulse when an update completes.
- commandDone  in  1  pulse from the nibble sender: current nibble finished.
- commandToSend  out  4  nibble to send.
- commandToSendRs  out  1  0 = instruction, 1 = data.
- read_busy  out  1  0 on high nibble, 1 on low nibble; the nibble sender polls BF after the low nibble.
- sendCommand_tick  out  1  one-cycle request to the nibble sender.

## Operation
- Accepted sendText: `text` is copied into a frame register. Later changes to `text` do not affect the update in progress.
- Each byte is sent as a high nibble, then a low nibble, with the same RS for both.
- A set-address byte is 0x80 | (line base + column), sent with RS = 0. A character byte is sent with RS = 1.
- Full update (SKIP_UNCHANGED = 0, forceFull = 1, or shadow invalid): for each line 0..NUM_LINES-1, send the set-address byte for column 0, then all LINE_LENGTH characters in column order.
- Shadow mode (SKIP_UNCHANGED = 1, shadow valid, forceFull = 0):
  - Positions are scanned line-major. Each frame char is compared with its shadow copy.
  - Equal: skip the position.
  - Different: if the tracked cursor ≠ (line, column), send set-address first. Then send the char. The cursor becomes (line, column+1).
  - The cursor is marked invalid at the start of each update.
- Shadow register and shadow-valid flag (present only when SKIP_UNCHANGED = 1):
  - The shadow is updated with each char as it is sent.
  - On a full update, shadow-valid is set at completion.
- State machine: IDLE → SCAN → (SET_ADDR) → SEND_HI → WAIT_HI → SEND_LO → WAIT_LO → NEXT → SCAN | DONE → IDLE.
  - SCAN handles one position per cycle.
  - In full mode SCAN never skips, and SET_ADDR is taken at column 0 only.
  - DONE asserts sendingDone and returns to IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, shadow-valid 0, frame and shadow registers 0.
- All outputs are registered. commandToSend, commandToSendRs and read_busy change on the same edge that raises sendCommand_tick. They hold until the next tick.
- sendCommand_tick is high for exactly one cycle per nibble.
- commandDone is honoured only in WAIT_HI or WAIT_LO, on or after the cycle following the tick. It is ignored elsewhere.
- Minimum gap from commandDone to the next tick is 2 cycles.
- sendText held high is accepted once per IDLE visit. sendText while busy is ignored.
- No-change update in shadow mode:
  - Exactly NUM_LINES·LINE_LENGTH SCAN cycles, then sendingDone.
  - No tick is issued.
  - busy is high for NUM_LINES·LINE_LENGTH+1 cycles.
- Full update issues exactly 2·NUM_LINES·(LINE_LENGTH+1) ticks.
- RESET mid-update:
  - Returns to IDLE on the next edge with all outputs 0.
  - No sendingDone is produced.
  - Shadow-valid is cleared, so the next update is full.
- Column index width is clog2(LINE_LENGTH+1). Address arithmetic is 7-bit.

## Test plan
- Full update, defaults, frame "HELLO WORLD     " / "0123456789ABCDEF", model answers commandDone 3 cycles after each tick → 68 ticks. Nibble sequence starts 8,0 (RS 0), 4,8 (RS 1, 'H'). Line 2 starts with 0xC0. sendingDone fires once.
- SKIP_UNCHANGED = 1, second update with identical frame → zero ticks, sendingDone exactly 33 cycles after sendText.
- SKIP_UNCHANGED = 1, only line 1 cols 3 and 4 changed → set-address 0xC3 then 2 chars: 6 ticks. Only col 3 and col 10 changed → 0xC3, char, 0xCA, char: 8 ticks.
- NUM_LINES = 4, LINE_LENGTH = 20, full update → set-address bytes 0x80, 0xC0, 0x94, 0xD4 in order; 168 ticks.
- RESET asserted during WAIT_LO of char 5 → next cycle all outputs 0, no sendingDone. Following sendText performs a full update even with SKIP_UNCHANGED = 1.
- `text` changed and sendText re-pulsed mid-update → transmitted bytes match the frame latched at start; the second request is ignored; forceFull = 1 with an unchanged frame → full 68-tick rewrite.
